// File: rtl/latch_bank_wr_sched.sv
// Round-robin write scheduler for a bank of level-sensitive latches.
// Each write runs grant -> setup -> enable pulse -> hold, with latch_d stable throughout.
module latch_bank_wr_sched #(
  parameter int NUM_REQ      = 4,
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 4,
  parameter int PULSE_CYCLES = 2,
  localparam int AW          = $clog2(DEPTH),
  localparam int GW          = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*AW-1:0]    req_addr,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     addr_err,
  output logic [WIDTH-1:0]         latch_d,
  output logic [DEPTH-1:0]         latch_en,
  output logic                     busy,
  output logic [GW-1:0]            grant_id
);

  localparam int CW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  state_t             state;
  logic [AW-1:0]      addr_q;
  logic [GW-1:0]      rr_ptr;
  logic [CW-1:0]      pulse_cnt;

  logic               found;
  logic [GW-1:0]      win;
  logic [AW-1:0]      win_addr;
  logic [WIDTH-1:0]   win_data;
  logic [GW-1:0]      cand;
  int unsigned        idx;
  logic [DEPTH-1:0]   en_dec;
  logic [NUM_REQ-1:0] ack_dec;
  logic               addr_oob;

  // Search starts just past the last grantee so it gets lowest priority next time.
  always_comb begin
    found    = 1'b0;
    win      = rr_ptr;
    win_addr = '0;
    win_data = '0;
    idx      = 0;
    cand     = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx  = (32'(rr_ptr) + i) % NUM_REQ;
      cand = GW'(idx);
      if (!found && req[cand]) begin
        found    = 1'b1;
        win      = cand;
        win_addr = req_addr[idx*AW +: AW];
        win_data = req_data[idx*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    addr_oob = (32'(addr_q) >= DEPTH);
    en_dec   = '0;
    for (int unsigned j = 0; j < DEPTH; j++)
      en_dec[j] = (32'(addr_q) == j);
    ack_dec = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      ack_dec[i] = (32'(grant_id) == i);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rr_ptr    <= GW'(NUM_REQ - 1);
      addr_q    <= '0;
      pulse_cnt <= '0;
      ack       <= '0;
      addr_err  <= 1'b0;
      latch_d   <= '0;
      latch_en  <= '0;
      busy      <= 1'b0;
      grant_id  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            addr_q   <= win_addr;
            latch_d  <= win_data;
            grant_id <= win;
            rr_ptr   <= win;
            busy     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          latch_en  <= en_dec;
          pulse_cnt <= CW'(PULSE_CYCLES - 1);
          state     <= PULSE;
        end
        PULSE: begin
          if (pulse_cnt == '0) begin
            latch_en <= '0;
            ack      <= ack_dec;
            addr_err <= addr_oob;
            state    <= HOLD;
          end else begin
            pulse_cnt <= pulse_cnt - 1'b1;
          end
        end
        HOLD: begin
          ack      <= '0;
          addr_err <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_latch_bank_wr_sched.sv
// Bench for latch_bank_wr_sched: directed and random writes against a
// transaction-timeline model, with a behavioural latch bank on the outputs.
module tb_latch_bank_wr_sched;

  localparam int NR = 4;
  localparam int W  = 8;
  localparam int D  = 3;
  localparam int P  = 2;
  localparam int AW = 2;
  localparam int GW = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic [NR-1:0]     req = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*W-1:0]   req_data = '0;
  logic [NR-1:0]     ack;
  logic              addr_err;
  logic [W-1:0]      latch_d;
  logic [D-1:0]      latch_en;
  logic              busy;
  logic [GW-1:0]     grant_id;

  always #5 clk = ~clk;

  latch_bank_wr_sched #(.NUM_REQ(NR), .WIDTH(W), .DEPTH(D), .PULSE_CYCLES(P)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr), .req_data(req_data),
    .ack(ack), .addr_err(addr_err), .latch_d(latch_d), .latch_en(latch_en),
    .busy(busy), .grant_id(grant_id)
  );

  // Model: off = cycles since the grant edge, -1 when no write is in flight.
  int              off = -1;
  int              ptr = NR - 1;
  int              m_gid = 0;
  int              m_addr = 0;
  logic [W-1:0]    m_data = '0;
  logic [D-1:0][W-1:0] bank = '0;
  logic [D-1:0][W-1:0] mbank = '0;
  int              passed = 0;
  int              failed = 0;
  int              total = 0;
  bit              drop_on_ack = 1'b0;
  bit              rec = 1'b0;
  int              order[$];
  int              ack_pulses = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int w;
    if (off < 0) begin
      if (|req) begin
        w = -1;
        for (int i = 1; i <= NR; i++)
          if (w < 0 && req[(ptr + i) % NR]) w = (ptr + i) % NR;
        m_gid  = w;
        ptr    = w;
        m_addr = int'(req_addr[w*AW +: AW]);
        m_data = req_data[w*W +: W];
        off    = 0;
      end
    end else begin
      off++;
      if (off == P + 2) off = -1;
    end
  endtask

  task automatic check_outputs();
    logic [31:0] e_en, e_ack;
    bit pulse;
    pulse = (off >= 1 && off <= P && m_addr < D);
    e_en  = pulse ? (32'd1 << m_addr) : 32'd0;
    e_ack = (off == P + 1) ? (32'd1 << m_gid) : 32'd0;
    chk("busy", busy, (off >= 0 && off <= P + 1) ? 1 : 0);
    chk("latch_en", latch_en, e_en);
    chk("ack", ack, e_ack);
    chk("addr_err", addr_err, (off == P + 1 && m_addr >= D) ? 1 : 0);
    chk("latch_d", latch_d, m_data);
    chk("grant_id", grant_id, m_gid);
    chk("en_onehot", 32'($countones(latch_en) <= 1), 1);
    for (int j = 0; j < D; j++)
      if (latch_en[j] === 1'b1) bank[j] = latch_d;
    if (pulse) mbank[m_addr] = m_data;
    chk("bank", bank, mbank);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    if (ack !== '0) ack_pulses++;
    if (rec && off == 0) order.push_back(int'(grant_id));
    if (drop_on_ack) req = req & ~ack;
  endtask

  // Entered at posedge+1; reset falls mid-cycle, outputs checked before any edge.
  task automatic assert_reset();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_en", latch_en, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", addr_err, 0);
    chk("rst_d", latch_d, 0);
    chk("rst_gid", grant_id, 0);
    off = -1; ptr = NR - 1; m_gid = 0; m_addr = 0; m_data = '0;
    bank = '0; mbank = '0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #3;
    reset_n = 1'b1;
  endtask

  task automatic wait_idle();
    req = '0;
    for (int n = 0; n < 20 && off >= 0; n++) step();
    chk("idle_reached", busy, 0);
  endtask

  task automatic rand_inputs();
    req      = NR'($urandom);
    req_addr = (NR*AW)'($urandom);
    req_data = (NR*W)'($urandom);
  endtask

  initial begin
    // T1: asynchronous reset with random requests, then lowest active req wins
    req      = NR'($urandom_range(1, 15));
    req_addr = (NR*AW)'($urandom);
    req_data = (NR*W)'($urandom);
    assert_reset();
    release_reset();
    for (int c = 0; c < 6; c++) step();

    // T2: single write from requester 1 to address 2
    wait_idle();
    drop_on_ack = 1'b1;
    req_addr = '0; req_data = '0;
    req_addr[1*AW +: AW] = 2'd2;
    req_data[1*W +: W]   = 8'hA5;
    req = 4'b0010;
    step();
    chk("t2_d", latch_d, 8'hA5);
    chk("t2_busy_k", busy, 1);
    step();
    chk("t2_en_k1", latch_en, 3'b100);
    step();
    chk("t2_en_k2", latch_en, 3'b100);
    step();
    chk("t2_ack_k3", ack, 4'b0010);
    chk("t2_en_k3", latch_en, 0);
    step();
    chk("t2_busy_k4", busy, 0);
    chk("t2_ack_k4", ack, 0);

    // T3: all requesters, each dropping on ack; order 0..3 twice
    wait_idle();
    assert_reset();
    release_reset();
    for (int r = 0; r < 2; r++) begin
      order.delete();
      rec = 1'b1;
      req_addr = (NR*AW)'($urandom);
      req_data = (NR*W)'($urandom);
      req = 4'hF;
      for (int c = 0; c < 4 * (P + 3) + 2; c++) step();
      rec = 1'b0;
      chk("t3_count", order.size(), 4);
      for (int i = 0; i < 4 && i < order.size(); i++) chk("t3_order", order[i], i);
    end

    // T4: req[0] and req[2] held, grants alternate
    wait_idle();
    drop_on_ack = 1'b0;
    order.delete();
    rec = 1'b1;
    req = 4'b0101;
    for (int c = 0; c < 4 * (P + 3); c++) step();
    rec = 1'b0;
    chk("t4_count", order.size(), 4);
    for (int i = 0; i < order.size(); i++) chk("t4_order", order[i], (i % 2) * 2);

    // T5: reset during the enable pulse, then a held req[3] runs a full write
    wait_idle();
    req_addr[3*AW +: AW] = 2'd1;
    req_data[3*W +: W]   = 8'h5A;
    req = 4'b1000;
    for (int n = 0; n < 10 && off != 1; n++) step();
    chk("t5_in_pulse", latch_en, 3'b010);
    assert_reset();
    release_reset();
    drop_on_ack = 1'b1;
    ack_pulses = 0;
    for (int c = 0; c < P + 4; c++) step();
    chk("t5_one_ack", ack_pulses, 1);
    chk("t5_gid", grant_id, 3);

    // T6: out-of-range address, no enable, ack with addr_err
    wait_idle();
    req_addr[2*AW +: AW] = 2'd3;
    req_data[2*W +: W]   = 8'h3C;
    req = 4'b0100;
    for (int c = 0; c < P + 2; c++) step();
    chk("t6_ack", ack, 4'b0100);
    chk("t6_err", addr_err, 1);
    step();
    chk("t6_err_clr", addr_err, 0);

    // Random traffic with a mid-run reset
    drop_on_ack = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (c == 150) begin
        assert_reset();
        release_reset();
      end
      if ($urandom_range(0, 3) != 0) rand_inputs();
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
